// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch unit: issues in-order word fetches under a credit limit,
// buffers returned instructions with their PCs, and flushes in-flight work on redirect.
module fetch_prefetch_unit #(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic                           clk,
    input  logic                           resetn,
    output logic                           imem_req_valid,
    input  logic                           imem_req_ready,
    output logic [XLEN-1:0]                imem_req_addr,
    input  logic                           imem_rsp_valid,
    input  logic [31:0]                    imem_rsp_data,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_pc,
    output logic                           inst_valid,
    input  logic                           inst_ready,
    output logic [31:0]                    inst_data,
    output logic [XLEN-1:0]                inst_pc,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e          state_q,    state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            req_valid_q, req_valid_d;
    logic [CW-1:0]   out_q,      out_d;
    logic [CW-1:0]   disc_q,     disc_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0]   pcq_wr_q,   pcq_wr_d;
    logic [PW-1:0]   pcq_rd_q,   pcq_rd_d;

    logic [XLEN-1:0] pcq_mem  [DEPTH];
    logic [31:0]     buf_data [DEPTH];
    logic [XLEN-1:0] buf_pc   [DEPTH];

    logic req_hs;
    logic rsp_acc;
    logic rsp_keep;
    logic pop;

    // Handshake qualification; a response with nothing in flight is a protocol error and ignored
    always_comb begin
        req_hs   = req_valid_q & imem_req_ready;
        rsp_acc  = imem_rsp_valid & (out_q != '0);
        rsp_keep = rsp_acc & (disc_q == '0) & ~redirect_valid & (state_q == ST_FETCH);
        pop      = (cnt_q != '0) & inst_ready;
    end

    // Next-state: fetch PC, in-flight/discard accounting, buffer pointers, FSM, request credit
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        out_d       = out_q;
        disc_d      = disc_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pcq_wr_d    = pcq_wr_q;
        pcq_rd_d    = pcq_rd_q;
        req_valid_d = 1'b0;

        if (req_hs) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            pcq_wr_d   = pcq_wr_q + PW'(1);
        end
        if (rsp_acc) begin
            pcq_rd_d = pcq_rd_q + PW'(1);
        end
        out_d = out_q + CW'(req_hs) - CW'(rsp_acc);

        if (rsp_acc && (disc_q != '0)) begin
            disc_d = disc_q - CW'(1);
        end

        if (rsp_keep) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(rsp_keep) - CW'(pop);

        if ((state_q == ST_FLUSH) && (disc_d == '0)) begin
            state_d = ST_FETCH;
        end

        // Redirect wins over everything: every request still in flight becomes a discard
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            disc_d     = out_d;
            state_d    = (out_d != '0) ? ST_FLUSH : ST_FETCH;
        end

        req_valid_d = (state_d == ST_FETCH) && ((SW'(cnt_d) + SW'(out_d)) < SW'(DEPTH));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_FETCH;
            fetch_pc_q  <= RESET_PC;
            req_valid_q <= 1'b0;
            out_q       <= '0;
            disc_q      <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pcq_wr_q    <= '0;
            pcq_rd_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_valid_q <= req_valid_d;
            out_q       <= out_d;
            disc_q      <= disc_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pcq_wr_q    <= pcq_wr_d;
            pcq_rd_q    <= pcq_rd_d;
        end
    end

    // Storage arrays; contents are only observed through valid-qualified pointers
    always_ff @(posedge clk) begin
        if (req_hs) begin
            pcq_mem[pcq_wr_q] <= fetch_pc_q;
        end
        if (rsp_keep) begin
            buf_data[wr_ptr_q] <= imem_rsp_data;
            buf_pc[wr_ptr_q]   <= pcq_mem[pcq_rd_q];
        end
    end

    always_comb begin
        imem_req_valid = req_valid_q;
        imem_req_addr  = fetch_pc_q;
        inst_valid     = (cnt_q != '0);
        inst_data      = inst_valid ? buf_data[rd_ptr_q] : 32'h0;
        inst_pc        = inst_valid ? buf_pc[rd_ptr_q]   : '0;
        fifo_count     = cnt_q;
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed self-checking bench for fetch_prefetch_unit: streaming, credit stall,
// redirect/flush, redirect alignment and PC wrap, asynchronous reset mid-flight.
module tb_fetch_prefetch_unit;

    logic        clk;
    logic        resetn;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [2:0]  fifo_count;

    int n_checks;
    int n_fail;

    fetch_prefetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fifo_count     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rsp(input logic v, input logic [31:0] a);
        imem_rsp_valid = v;
        imem_rsp_data  = v ? instr(a) : 32'h0;
    endtask

    task automatic clear_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
    endtask

    // Leaves the bench at a falling edge with the first request already raised
    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        repeat (2) step();
        resetn = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        clear_inputs();

        // Reset values
        step();
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_inst_data", inst_data, 32'h0);
        check_eq("rst_inst_pc", inst_pc, 32'h0);
        check_eq("rst_addr", imem_req_addr, 32'h0);
        resetn = 1'b1;
        step();
        check_eq("rel_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("rel_addr", imem_req_addr, 32'h0);

        // Streaming: one instruction per cycle, write and pop together
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        step();
        check_eq("str_addr0", imem_req_addr, 32'h4);
        check_eq("str_noinst", 32'(inst_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            rsp(1'b1, 32'(4 * k));
            step();
            check_eq("str_inst_valid", 32'(inst_valid), 32'd1);
            check_eq("str_inst_pc", inst_pc, 32'(4 * k));
            check_eq("str_inst_data", inst_data, instr(32'(4 * k)));
            check_eq("str_count", 32'(fifo_count), 32'd1);
            check_eq("str_addr", imem_req_addr, 32'(4 * k + 8));
        end
        rsp(1'b0, 32'h0);

        // Credit stall with decode blocked
        do_reset();
        imem_req_ready = 1'b1;
        step();
        rsp(1'b1, 32'h0);  step();
        rsp(1'b1, 32'h4);  step();
        rsp(1'b1, 32'h8);  step();
        check_eq("cr_valid_drop", 32'(imem_req_valid), 32'd0);
        rsp(1'b1, 32'hC);  step();
        check_eq("cr_count4", 32'(fifo_count), 32'd4);
        check_eq("cr_req_off", 32'(imem_req_valid), 32'd0);
        check_eq("cr_addr16", imem_req_addr, 32'h10);
        check_eq("cr_head_pc", inst_pc, 32'h0);
        rsp(1'b0, 32'h0);  step();
        check_eq("cr_no5th", 32'(imem_req_valid), 32'd0);
        inst_ready = 1'b1; step();
        check_eq("cr_pop_count", 32'(fifo_count), 32'd3);
        check_eq("cr_pop_req", 32'(imem_req_valid), 32'd1);
        check_eq("cr_pop_head", inst_pc, 32'h4);
        inst_ready = 1'b0; step();
        check_eq("cr_one_req", 32'(imem_req_valid), 32'd0);
        check_eq("cr_one_addr", imem_req_addr, 32'h14);

        // Redirect with two outstanding and one buffered
        do_reset();
        imem_req_ready = 1'b1;
        step();
        step();
        rsp(1'b1, 32'h0);  step();
        check_eq("rd_pre_count", 32'(fifo_count), 32'd1);
        rsp(1'b0, 32'h0);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        check_eq("rd_count0", 32'(fifo_count), 32'd0);
        check_eq("rd_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rd_flush_req", 32'(imem_req_valid), 32'd0);
        check_eq("rd_addr", imem_req_addr, 32'h100);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        rsp(1'b1, 32'h4);  step();
        check_eq("rd_drop1_req", 32'(imem_req_valid), 32'd0);
        check_eq("rd_drop1_inst", 32'(inst_valid), 32'd0);
        rsp(1'b1, 32'h8);  step();
        check_eq("rd_fetch_req", 32'(imem_req_valid), 32'd1);
        check_eq("rd_fetch_addr", imem_req_addr, 32'h100);
        check_eq("rd_drop2_inst", 32'(inst_valid), 32'd0);
        rsp(1'b0, 32'h0);  step();
        check_eq("rd_next_addr", imem_req_addr, 32'h104);
        rsp(1'b1, 32'h100); step();
        check_eq("rd_new_valid", 32'(inst_valid), 32'd1);
        check_eq("rd_new_pc", inst_pc, 32'h100);
        check_eq("rd_new_data", inst_data, instr(32'h100));
        rsp(1'b0, 32'h0);

        // Redirect, response and pop in the same cycle
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        step();
        rsp(1'b1, 32'h0);  step();
        check_eq("sc_pre_valid", 32'(inst_valid), 32'd1);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        rsp(1'b1, 32'h4);  step();
        check_eq("sc_count0", 32'(fifo_count), 32'd0);
        check_eq("sc_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("sc_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("sc_addr", imem_req_addr, 32'h40);
        redirect_valid = 1'b0;
        rsp(1'b0, 32'h0);  step();
        check_eq("sc_no_spurious", 32'(inst_valid), 32'd0);
        check_eq("sc_count_hold", 32'(fifo_count), 32'd0);

        // Redirect alignment and PC wrap
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step();
        check_eq("al_addr", imem_req_addr, 32'h200);
        redirect_pc = 32'hFFFF_FFFC;
        step();
        check_eq("wr_pre_addr", imem_req_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        step();
        check_eq("wr_addr0", imem_req_addr, 32'h0);
        imem_req_ready = 1'b0;

        // Asynchronous reset with three entries and one request in flight
        do_reset();
        imem_req_ready = 1'b1;
        step();
        rsp(1'b1, 32'h0);  step();
        rsp(1'b1, 32'h4);  step();
        rsp(1'b1, 32'h8);  step();
        check_eq("ar_count3", 32'(fifo_count), 32'd3);
        rsp(1'b0, 32'h0);
        #1 resetn = 1'b0;
        #1;
        check_eq("ar_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("ar_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("ar_count", 32'(fifo_count), 32'd0);
        check_eq("ar_inst_data", inst_data, 32'h0);
        check_eq("ar_inst_pc", inst_pc, 32'h0);
        check_eq("ar_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        resetn         = 1'b1;
        imem_req_ready = 1'b0;
        rsp(1'b1, 32'hC);
        step();
        check_eq("ar_rel_req", 32'(imem_req_valid), 32'd1);
        check_eq("ar_rel_addr", imem_req_addr, 32'h0);
        check_eq("ar_late_count", 32'(fifo_count), 32'd0);
        rsp(1'b0, 32'h0);  step();
        check_eq("ar_late_inst", 32'(inst_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
